// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential ROM fetch into a small FIFO toward decode.
// Credit-based issue, one word per cycle, single-cycle flush/redirect.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic          pending_q, pending_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          issue, push, pop, nempty;

  // Credit counts the in-flight word so a full FIFO is never overrun.
  assign issue = rst && !flush_i
    && ((count_q + CW'(pending_q)) < CW'(DEPTH));
  assign push   = pending_q && !drop_q && !flush_i;
  assign nempty = (count_q != '0);
  assign head   = mem_q[rd_ptr_q];

  assign rom_ce_o     = issue;
  assign rom_addr_o   = fetch_pc_q;
  assign inst_valid_o = nempty && !flush_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = nempty ? head.inst : '0;
  assign pc_o         = nempty ? head.pc   : '0;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    pending_d    = issue;
    drop_d       = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (issue) begin
      fetch_pc_d   = fetch_pc_q + 32'd4;
      pending_pc_d = fetch_pc_q;
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      fetch_pc_d = {flush_pc_i[31:2], 2'b00};
      drop_d     = pending_q;
      pending_d  = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      pending_q    <= 1'b0;
      drop_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: pending_pc_q, inst: rom_data_i};
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(push && count_q == CW'(DEPTH)));
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed vector table plus corner sequences.
// ROM model returns the bitwise inverse of the requested address.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom_addr, rom_data, flush_pc, inst, pc;
  logic        rom_ce, flush, inst_valid, ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce),
    .rom_data_i(rom_data),
    .flush_i(flush), .flush_pc_i(flush_pc),
    .inst_o(inst), .pc_o(pc),
    .inst_valid_o(inst_valid), .inst_ready_i(ready)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) rom_data <= 32'hBAD0_BAD0;
    else rom_data <= rom_ce ? ~rom_addr : 32'hBAD0_BAD0;
  end

  typedef struct {
    logic [1:0]  fr;
    logic [31:0] fpc;
    logic [1:0]  vc;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic [1:0] fr,
                              input logic [31:0] fpc,
                              input logic [1:0] vc,
                              input logic [31:0] p,
                              input logic [31:0] a);
    vec_t v;
    v.fr = fr; v.fpc = fpc; v.vc = vc; v.pc = p; v.addr = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [31:0] p);
    chk({nm, ".valid"}, 32'(inst_valid), 32'd1);
    chk({nm, ".pc"}, pc, p);
    chk({nm, ".inst"}, inst, ~p);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".valid"}, 32'(inst_valid), 32'd0);
    chk({nm, ".ce"}, 32'(rom_ce), 32'd0);
    chk({nm, ".addr"}, rom_addr, 32'h0);
    chk({nm, ".inst"}, inst, 32'h0);
    chk({nm, ".pc"}, pc, 32'h0);
  endtask

  initial begin
    int issues;
    int bad_head;
    string nm;
    flush = 1'b0; flush_pc = '0; ready = 1'b0;

    // flush/ready, flush pc, valid/ce, head pc, rom addr
    tbl[0]  = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h0);
    tbl[1]  = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h4);
    tbl[2]  = mk(2'b01, 32'h0,   2'b11, 32'h0,   32'h8);
    tbl[3]  = mk(2'b01, 32'h0,   2'b11, 32'h4,   32'hC);
    tbl[4]  = mk(2'b00, 32'h0,   2'b11, 32'h8,   32'h10);
    tbl[5]  = mk(2'b00, 32'h0,   2'b11, 32'h8,   32'h14);
    tbl[6]  = mk(2'b00, 32'h0,   2'b10, 32'h8,   32'h18);
    tbl[7]  = mk(2'b01, 32'h0,   2'b10, 32'h8,   32'h18);
    tbl[8]  = mk(2'b01, 32'h0,   2'b11, 32'hC,   32'h18);
    tbl[9]  = mk(2'b11, 32'h103, 2'b00, 32'h0,   32'h1C);
    tbl[10] = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h100);
    tbl[11] = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h104);
    tbl[12] = mk(2'b01, 32'h0,   2'b11, 32'h100, 32'h108);
    tbl[13] = mk(2'b11, 32'h200, 2'b00, 32'h0,   32'h10C);
    tbl[14] = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h200);
    tbl[15] = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h204);
    tbl[16] = mk(2'b01, 32'h0,   2'b11, 32'h200, 32'h208);
    tbl[17] = mk(2'b11, 32'h300, 2'b00, 32'h0,   32'h20C);
    tbl[18] = mk(2'b11, 32'h400, 2'b00, 32'h0,   32'h300);
    tbl[19] = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h400);
    tbl[20] = mk(2'b01, 32'h0,   2'b01, 32'h0,   32'h404);
    tbl[21] = mk(2'b01, 32'h0,   2'b11, 32'h400, 32'h408);
    tbl[22] = mk(2'b01, 32'h0,   2'b11, 32'h404, 32'h40C);

    repeat (2) @(negedge clk);
    #1 chk_reset("rst0");

    // table: first entry is cycle 0 after reset release
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 23; i++) begin
      flush    = tbl[i].fr[1];
      ready    = tbl[i].fr[0];
      flush_pc = tbl[i].fpc;
      #1;
      nm = $sformatf("vec%0d", i);
      chk({nm, ".valid"}, 32'(inst_valid), 32'(tbl[i].vc[1]));
      chk({nm, ".ce"}, 32'(rom_ce), 32'(tbl[i].vc[0]));
      chk({nm, ".addr"}, rom_addr, tbl[i].addr);
      if (tbl[i].vc[1]) begin
        chk({nm, ".pc"}, pc, tbl[i].pc);
        chk({nm, ".inst"}, inst, ~tbl[i].pc);
      end
      @(negedge clk);
    end
    flush = 1'b0;

    // stall from reset: exactly DEPTH issues, head holds PC 0
    rst = 1'b0; ready = 1'b0;
    #1 chk_reset("rst1");
    @(negedge clk);
    rst = 1'b1;
    issues = 0; bad_head = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rom_ce) issues++;
      if (c >= 2 && (!inst_valid || pc !== 32'h0 || inst !== ~32'h0))
        bad_head++;
      @(negedge clk);
    end
    chk("stall.issues", 32'(issues), 32'd4);
    chk("stall.head_unstable", 32'(bad_head), 32'd0);
    #1 chk("stall.ce", 32'(rom_ce), 32'd0);

    // drain in order, fetch resumes at 0x10 once a slot frees
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      nm = $sformatf("drain%0d", c);
      chk_head(nm, 32'(c * 4));
      if (c == 0) chk({nm, ".ce"}, 32'(rom_ce), 32'd0);
      if (c == 1) begin
        chk({nm, ".ce"}, 32'(rom_ce), 32'd1);
        chk({nm, ".addr"}, rom_addr, 32'h10);
      end
      @(negedge clk);
    end

    // redirect near the top of the address space, wraps to 0
    flush = 1'b1; flush_pc = 32'hFFFF_FFFB;
    #1 chk("wrap.flushvalid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      nm = $sformatf("wrap%0d", k);
      if (k < 3) chk({nm, ".valid"}, 32'(inst_valid), 32'd0);
      else chk_head(nm, 32'hFFFF_FFF8 + 32'(4 * (k - 3)));
      @(negedge clk);
    end

    // fill to full, then async reset in the middle of a cycle
    ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("full.ce", 32'(rom_ce), 32'd0);
    chk("full.valid", 32'(inst_valid), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset("arst");
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    #1;
    chk("restart0.ce", 32'(rom_ce), 32'd1);
    chk("restart0.addr", rom_addr, 32'h0);
    chk("restart0.valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    #1 chk("restart1.valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    #1 chk_head("restart2", 32'h0);
    @(negedge clk);
    #1 chk_head("restart3", 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
